// File: rtl/iic_req_arb.sv
// ============================================================================
// Module   : iic_req_arb
// Purpose  : Two-requester round-robin front end for a single shared IIC master.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iic_req_arb #(
    parameter int               TO_W   = 24,
    parameter logic [TO_W-1:0]  TO_CYC = TO_W'(12_000_000)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  i_wr_req,
    input  logic [1:0]  i_rd_req,
    input  logic [31:0] i_addr,
    input  logic [11:0] i_wr_byte_num,
    input  logic [11:0] i_rd_byte_num,
    input  logic [15:0] i_wr_data,
    output logic [7:0]  o_rd_data,
    output logic [1:0]  o_work_done,
    output logic [1:0]  o_req_new_byte,
    output logic [1:0]  o_timeout,
    output logic        o_iic_wr_req,
    output logic        o_iic_rd_req,
    output logic [15:0] o_iic_addr,
    output logic [5:0]  o_iic_wr_byte_num,
    output logic [5:0]  o_iic_rd_byte_num,
    output logic [7:0]  o_iic_wr_data,
    input  logic [7:0]  i_iic_rd_data,
    input  logic        i_iic_work_done,
    input  logic        i_iic_req_new_byte
);

    localparam logic [TO_W-1:0] TO_LAST = TO_CYC - 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            gnt;
    logic            gnt_vld;
    logic            last_gnt;
    logic            is_wr;
    logic [TO_W-1:0] cnt;
    logic            wd_d;
    logic [1:0]      pending;
    logic            pick;
    logic            wd_rise;
    logic            to_hit;
    logic            to_evt;
    logic            active;
    logic [1:0]      gnt_oh;

    assign pending = i_wr_req | i_rd_req;
    // Under contention the requester that was not served last wins.
    assign pick    = (pending == 2'b11) ? ~last_gnt : pending[1];
    assign wd_rise = i_iic_work_done & ~wd_d;
    assign to_hit  = (cnt == TO_LAST);
    assign active  = (state == S_ISSUE) || (state == S_BUSY);
    assign gnt_oh  = gnt ? 2'b10 : 2'b01;

    always_comb begin
        state_nxt      = state;
        to_evt         = 1'b0;
        o_iic_wr_req   = 1'b0;
        o_iic_rd_req   = 1'b0;
        o_work_done    = 2'b00;
        o_timeout      = 2'b00;
        o_req_new_byte = 2'b00;
        o_iic_wr_data  = 8'h00;
        if (active) begin
            o_req_new_byte = i_iic_req_new_byte ? gnt_oh : 2'b00;
            o_iic_wr_data  = gnt ? i_wr_data[15:8] : i_wr_data[7:0];
        end
        case (state)
            S_IDLE: begin
                if (gnt_vld) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (to_hit) begin
                    to_evt    = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    o_iic_wr_req = is_wr;
                    o_iic_rd_req = ~is_wr;
                    if (i_iic_req_new_byte || !i_iic_work_done) state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                // A completion edge in the final timeout cycle still counts as done.
                if (wd_rise) begin
                    state_nxt = S_DONE;
                end else if (to_hit) begin
                    to_evt    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                o_work_done = gnt_oh;
                state_nxt   = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (to_evt) o_timeout = gnt_oh;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            gnt               <= 1'b0;
            gnt_vld           <= 1'b0;
            last_gnt          <= 1'b1;
            is_wr             <= 1'b0;
            cnt               <= '0;
            wd_d              <= 1'b1;
            o_rd_data         <= 8'h00;
            o_iic_addr        <= 16'h0000;
            o_iic_wr_byte_num <= 6'd0;
            o_iic_rd_byte_num <= 6'd0;
        end else begin
            state     <= state_nxt;
            wd_d      <= i_iic_work_done;
            o_rd_data <= i_iic_rd_data;
            // Grant and transaction fields are captured one edge before ISSUE.
            if (state == S_IDLE) begin
                if (gnt_vld) begin
                    gnt_vld <= 1'b0;
                    cnt     <= '0;
                end else if (|pending) begin
                    gnt_vld           <= 1'b1;
                    gnt               <= pick;
                    is_wr             <= i_wr_req[pick];
                    o_iic_addr        <= pick ? i_addr[31:16]        : i_addr[15:0];
                    o_iic_wr_byte_num <= pick ? i_wr_byte_num[11:6]  : i_wr_byte_num[5:0];
                    o_iic_rd_byte_num <= pick ? i_rd_byte_num[11:6]  : i_rd_byte_num[5:0];
                end
            end else if (active) begin
                cnt <= cnt + 1'b1;
            end
            if ((state == S_DONE) || to_evt) last_gnt <= gnt;
        end
    end

endmodule

`default_nettype wire

// File: doc/iic_req_arb.md
IIC_REQ_ARB -- requirements
Module: iic_req_arb

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset, per these parameters and ports.
REQ-002 Parameter TO_W, default 24, timeout counter width.
REQ-003 Parameter TO_CYC, default 24'd12_000_000, cycles from ISSUE entry before timeout.
REQ-004 clk  input  1  system clock; all flops on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 i_wr_req  input  2  per-requester write request, level; bit n = requester n.
REQ-007 i_rd_req  input  2  per-requester read request, level.
REQ-008 i_addr  input  32  {req1,req0} 16-bit IIC addresses.
REQ-009 i_wr_byte_num  input  12  {req1,req0} 6-bit write byte counts.
REQ-010 i_rd_byte_num  input  12  {req1,req0} 6-bit read byte counts.
REQ-011 i_wr_data  input  16  {req1,req0} 8-bit write data.
REQ-012 o_rd_data  output  8  read data, broadcast to both requesters.
REQ-013 o_work_done  output  2  one-cycle completion pulse to granted requester.
REQ-014 o_req_new_byte  output  2  master's new-byte strobe routed to granted requester.
REQ-015 o_timeout  output  2  one-cycle timeout pulse to granted requester.
REQ-016 o_iic_wr_req / o_iic_rd_req  output  1 each  requests to the shared IIC master.
REQ-017 o_iic_addr  output  16  latched address of granted requester.
REQ-018 o_iic_wr_byte_num / o_iic_rd_byte_num  output  6 each  latched byte counts.
REQ-019 o_iic_wr_data  output  8  i_wr_data slice of granted requester, live mux on registered grant.
REQ-020 i_iic_rd_data / i_iic_work_done / i_iic_req_new_byte  input  8/1/1  IIC master status; work_done high = master idle.

Function
REQ-021 FSM states: IDLE, ISSUE, BUSY, DONE.
REQ-022 IDLE: pending(n) = i_wr_req[n]|i_rd_req[n]; any pending -> register grant g, latch addr/byte_nums/type of g, go ISSUE next edge.
REQ-023 Arbitration: round-robin; requester not equal last_grant wins contention; sole pending requester always wins.
REQ-024 Type: i_wr_req[g]=1 -> write (wins if both set), else read; latched at grant.
REQ-025 ISSUE: o_iic_wr_req or o_iic_rd_req (per type) held high; exit to BUSY when i_iic_req_new_byte=1 or i_iic_work_done=0.
REQ-026 BUSY: requests low; exit to DONE on rising edge of i_iic_work_done (1d-delayed compare).
REQ-027 DONE: o_work_done[g]=1 for exactly one cycle, last_grant<=g, return IDLE next edge.
REQ-028 o_req_new_byte[g]=i_iic_req_new_byte only in ISSUE/BUSY; other bit and other states 0.
REQ-029 o_rd_data = i_iic_rd_data registered, one-cycle latency; valid when o_work_done pulses.
REQ-030 Timeout counter cleared on ISSUE entry, increments in ISSUE/BUSY; at TO_CYC-1 without done -> o_timeout[g] one cycle, requests low, IDLE; last_grant<=g; no o_work_done.
REQ-031 Done edge and timeout same cycle: done wins, no timeout pulse.
REQ-032 Requests dropped by requester mid-transaction are ignored until IDLE.
REQ-033 Requester must deassert request the cycle after o_work_done/o_timeout; IDLE re-arbitrates on current levels.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE, last_grant=1, counter 0, all outputs 0, including mid-transaction.
REQ-035 First arbitration after reset release SHALL grant requester 0 under contention.

Verification
REQ-036 Req0 write, addr 16'h3d00, data 8'h03, 1 byte -> o_iic_wr_req=1 two edges later, o_iic_addr=16'h3d00, o_iic_wr_data=8'h03; after work_done rise o_work_done=2'b01 for one cycle.
REQ-037 Both requesters after reset, held until served -> req0 served then req1; third contention -> req0.
REQ-038 Req1 read, rd_byte_num=1, master returns 8'h76 -> o_rd_data=8'h76 when o_work_done=2'b10.
REQ-039 TO_CYC=16, master never acknowledges -> o_timeout=2'b01 16 cycles after ISSUE entry, o_iic_wr_req=0, IDLE, o_work_done stays 0.
REQ-040 rst_n low during BUSY -> all outputs 0 without clock edge; after release, new req1 write granted and completed normally.
REQ-041 Req0 with both wr and rd set -> write issued, o_iic_rd_req stays 0.
